code_serializer: RTL

CODE_SERIALIZER -- requirements
Module: code_serializer

---
 rtl/code_serializer.sv | 100 ++++++++++
 1 files changed

// File: rtl/code_serializer.sv
// rtl/code_serializer.sv - parallel code word to MSB-first serial stream with guard-zero gap
// Each accepted code is followed by GAP zero cycles; done marks the last of them.
module code_serializer #(
   parameter int WIDTH = 6,
   parameter int GAP   = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic             d_out,
   output logic             busy,
   output logic             done
);

   localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_GAP = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] sreg, sreg_next;
   logic             d_next;
   logic             done_next;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state <= S_IDLE;
         cnt   <= '0;
         sreg  <= '0;
         d_out <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         sreg  <= sreg_next;
         d_out <= d_next;
         done  <= done_next;
      end
   end

   // sreg holds the bits still to be sent, already left-aligned so its MSB is the next bit out
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      sreg_next  = sreg;
      d_next     = 1'b0;
      done_next  = 1'b0;
      case (state)
         S_IDLE: begin
            if (code_valid) begin
               sreg_next  = {code_in[WIDTH-2:0], 1'b0};
               d_next     = code_in[WIDTH-1];
               cnt_next   = '0;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt == LAST_BIT) begin
               state_next = S_GAP;
               cnt_next   = '0;
               sreg_next  = '0;
               done_next  = (GAP == 1);
            end else begin
               d_next    = sreg[WIDTH-1];
               sreg_next = {sreg[WIDTH-2:0], 1'b0};
               cnt_next  = cnt + CNT_ONE;
            end
         end
         S_GAP: begin
            if (cnt == LAST_GAP) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next  = cnt + CNT_ONE;
               done_next = ((cnt + CNT_ONE) == LAST_GAP);
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
            sreg_next  = '0;
         end
      endcase
   end

   assign code_ready = (state == S_IDLE);
   assign busy       = ~code_ready;

endmodule
